led_share_ctrl: RTL and testbench
=================================

# led_share_ctrl

Time-shares the board RGB status LED (d6/green/blue) between up to N_REQ requesters with a round-robin arbiter and fixed display slots, and generates the per-requester blink pattern. It also drives the FPGA_LED heartbeat and a DEBUGPORT1 strobe that marks each ownership change for scope capture. It sits between the status-producing blocks and the top-level LED pins, replacing free-running per-LED blink logic.

## Interface
- N_REQ, 3: number of requesters (2..8)
- TICK_DIV, 250000: CLK25 cycles per tick (10 ms at 25 MHz)
- SLOT_TICKS, 100: ticks per display slot when others are waiting (1 s)
- BLINK_TICKS, 25: ticks per blink half-period (250 ms)
- HB_TICKS, 50: ticks per heartbeat half-period
- CLK25  in  1  25 MHz board clock, sole clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester display request, level
- color  in  3*N_REQ  per-requester RGB, bits [3i+2:3i] = {r,g,b}, 1 = lit
- blink  in  N_REQ  per-requester blink enable
- grant  out  N_REQ  one-hot current owner, 0 when none
- d6_led, gren_led, blue_led  out  1 each  RGB LED pins, active-low (1 = off)
- fpga_led  out  1  heartbeat, toggles every HB_TICKS
- debug_pin  out  1  one-cycle high pulse on every grant change

## Operation
- Reset values: grant 0, d6_led/gren_led/blue_led 1, fpga_led 1, debug_pin 0, state IDLE, prescaler 0, round-robin pointer so requester 0 wins first.
- Tick: prescaler counts 0..TICK_DIV-1; tick pulses one cycle when count = TICK_DIV-1, then wraps to 0. Free-running; never reset except by rst_n.
- States: IDLE, SHOW, GAP.
- IDLE: LEDs off, grant 0. Any req bit set -> SHOW; owner = first set req at or after pointer (wrapping). Not tick-aligned.
- Entering SHOW: latch owner color and blink bit (later changes ignored until next grant); slot count 0; blink phase = on, blink count 0; pointer = owner+1 mod N_REQ.
- SHOW: LEDs = ~latched color when phase on (or blink=0), all 1 when phase off. Blink count advances per tick; at BLINK_TICKS toggles phase and clears. Slot count advances per tick.
- SHOW exits: owner req low (any cycle) -> GAP. Slot count reaches SLOT_TICKS with another req pending -> GAP. Slot expiry with no other req -> stay, slot count 0, blink unaffected.
- GAP: grant 0, LEDs off, lasts until the next tick inclusive; on that tick, any req -> SHOW via arbitration, else IDLE.
- debug_pin: high for one cycle after any cycle in which registered grant changed value (including to 0).
- fpga_led: toggles on every HB_TICKS-th tick, independent of arbitration.

## Timing
- All outputs registered; grant and LED pins update on the same edge.
- req rising in IDLE -> grant asserted on the next CLK25 edge (1-cycle latency).
- Owner req fall -> grant 0 and LEDs off on the next edge.
- Simultaneous owner drop and slot expiry: drop wins, GAP.
- Owner re-raising req during GAP competes normally; pointer already moved past it.
- Counters sized with $clog2 of their parameter; no wrap beyond terminal counts.
- rst_n low asynchronously forces all reset values, including mid-SHOW; release sampled synchronously, first arbitration no earlier than the cycle after release.

## Structure
- Shared package led_pkg: state enum (IDLE, SHOW, GAP), rgb_t (3-bit {r,g,b}), LED_OFF constant (3'b111 at pins).
- Sub-module led_tick_prescaler (TICK_DIV parameter, CLK25/rst_n in, tick out), reused by other board-status blocks.
- Arbiter, slot/blink counters, heartbeat and debug strobe stay in led_share_ctrl.

## Test plan
Bench parameters: N_REQ=3, TICK_DIV=4, SLOT_TICKS=3, BLINK_TICKS=2, HB_TICKS=5.
- Reset: rst_n low mid-SHOW -> grant 000, LEDs 111, fpga_led 1, debug_pin 0 in the same cycle, without waiting for a clock edge.
- Single requester: req=001, color0=100, blink0=0 -> next edge grant 001, pins {d6,gren,blue}=011, held beyond SLOT_TICKS, debug_pin one pulse only.
- Blink: req=010, color1=010, blink1=1 -> gren_led low 2 ticks, high 2 ticks, repeating; d6/blue stay 1.
- Round-robin: req=111 from reset -> grants 001, 010, 100, 001, each 3 ticks of SHOW, 1-tick GAP of grant 000 between, debug_pin pulse on every change.
- Early release: owner 001 drops req at tick 1 while req=011 -> grant 000 next edge, grant 010 after next tick.
- Color latch: change color0 from 100 to 001 mid-slot -> pins unchanged until next grant of requester 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the board status LED blocks: display FSM states and the RGB
// payload, where a lit colour is 1 and the LED pins are active-low.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t LED_OFF = 3'b111;

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running divider: registered one-cycle tick every TICK_DIV clocks,
// high while the internal count sits at its terminal value.
module led_tick_prescaler #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic CLK25,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;

  assign w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);

  // Tick is registered against the next count so it lines up with count == last.
  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= (w_cnt_nxt == CNT_LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/led_share_ctrl.sv
// Round-robin time-sharing of the RGB status LED between requesters, with
// per-owner blink, FPGA heartbeat and a debug strobe on every ownership change.
module led_share_ctrl
  import led_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned TICK_DIV    = 250000,
  parameter int unsigned SLOT_TICKS  = 100,
  parameter int unsigned BLINK_TICKS = 25,
  parameter int unsigned HB_TICKS    = 50
) (
  input  logic               CLK25,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] color,
  input  logic [N_REQ-1:0]   blink,
  output logic [N_REQ-1:0]   grant,
  output logic               d6_led,
  output logic               gren_led,
  output logic               blue_led,
  output logic               fpga_led,
  output logic               debug_pin
);

  localparam int unsigned IDX_W   = $clog2(N_REQ);
  localparam int unsigned SLOT_W  = $clog2(SLOT_TICKS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned HB_W    = $clog2(HB_TICKS + 1);

  logic w_tick;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  rgb_t               r_color, w_color_nxt;
  logic               r_blink_en, w_blink_en_nxt;
  logic               r_phase, w_phase_nxt;
  logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic [SLOT_W-1:0]  r_slot_cnt, w_slot_cnt_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt, r_grant_d;
  rgb_t               r_pins, w_pins_nxt;
  logic               r_debug;
  logic [HB_W-1:0]    r_hb_cnt;
  logic               r_fpga_led;

  logic [IDX_W-1:0]   w_arb, w_arb_lo, w_arb_hi;
  logic               w_arb_hit;
  rgb_t               w_arb_color;
  logic               w_arb_blink;
  logic [N_REQ-1:0]   w_owner_oh;
  logic               w_owner_req;
  logic               w_other_pend;
  logic               w_enter;

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .CLK25 (CLK25),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_owner_oh   = N_REQ'(1) << r_owner;
  assign w_owner_req  = |(req & w_owner_oh);
  assign w_other_pend = |(req & ~w_owner_oh);

  // Arbiter: first set req at or after the pointer, else lowest set req (wrap).
  always_comb begin
    w_arb_lo    = '0;
    w_arb_hi    = '0;
    w_arb_hit   = 1'b0;
    w_arb_color = LED_OFF;
    w_arb_blink = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_arb_lo = IDX_W'(i);
        if (IDX_W'(i) >= r_ptr) begin
          w_arb_hi  = IDX_W'(i);
          w_arb_hit = 1'b1;
        end
      end
    end
    w_arb = w_arb_hit ? w_arb_hi : w_arb_lo;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == w_arb) begin
        w_arb_color = color[3*i +: 3];
        w_arb_blink = blink[i];
      end
    end
  end

  // Display FSM next state, plus registered grant/pin values derived from it.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_ptr_nxt       = r_ptr;
    w_color_nxt     = r_color;
    w_blink_en_nxt  = r_blink_en;
    w_phase_nxt     = r_phase;
    w_blink_cnt_nxt = r_blink_cnt;
    w_slot_cnt_nxt  = r_slot_cnt;
    w_grant_nxt     = '0;
    w_pins_nxt      = LED_OFF;
    w_enter         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|req) w_enter = 1'b1;
      end
      ST_SHOW: begin
        if (!w_owner_req) begin
          w_state_nxt = ST_GAP;
        end else if (w_tick) begin
          if (r_slot_cnt == SLOT_W'(SLOT_TICKS - 1)) begin
            w_slot_cnt_nxt = '0;
            if (w_other_pend) w_state_nxt = ST_GAP;
          end else begin
            w_slot_cnt_nxt = r_slot_cnt + SLOT_W'(1);
          end
          if (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
          end else begin
            w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          if (|req) w_enter = 1'b1;
          else      w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // New grant: latch owner payload so later input changes are ignored.
    if (w_enter) begin
      w_state_nxt     = ST_SHOW;
      w_owner_nxt     = w_arb;
      w_ptr_nxt       = (w_arb == IDX_W'(N_REQ - 1)) ? '0 : w_arb + IDX_W'(1);
      w_color_nxt     = w_arb_color;
      w_blink_en_nxt  = w_arb_blink;
      w_phase_nxt     = 1'b1;
      w_blink_cnt_nxt = '0;
      w_slot_cnt_nxt  = '0;
    end

    if (w_state_nxt == ST_SHOW) begin
      w_grant_nxt = N_REQ'(1) << w_owner_nxt;
      if (w_phase_nxt || !w_blink_en_nxt) w_pins_nxt = ~w_color_nxt;
    end
  end

  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_color     <= LED_OFF;
      r_blink_en  <= 1'b0;
      r_phase     <= 1'b1;
      r_blink_cnt <= '0;
      r_slot_cnt  <= '0;
      r_grant     <= '0;
      r_grant_d   <= '0;
      r_pins      <= LED_OFF;
      r_debug     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_ptr       <= w_ptr_nxt;
      r_color     <= w_color_nxt;
      r_blink_en  <= w_blink_en_nxt;
      r_phase     <= w_phase_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_slot_cnt  <= w_slot_cnt_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_d   <= r_grant;
      r_pins      <= w_pins_nxt;
      r_debug     <= (r_grant != r_grant_d);
    end
  end

  // Heartbeat runs off the shared tick, independent of arbitration.
  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) begin
      r_hb_cnt   <= '0;
      r_fpga_led <= 1'b1;
    end else if (w_tick) begin
      if (r_hb_cnt == HB_W'(HB_TICKS - 1)) begin
        r_hb_cnt   <= '0;
        r_fpga_led <= ~r_fpga_led;
      end else begin
        r_hb_cnt <= r_hb_cnt + HB_W'(1);
      end
    end
  end

  assign grant     = r_grant;
  assign d6_led    = r_pins.r;
  assign gren_led  = r_pins.g;
  assign blue_led  = r_pins.b;
  assign fpga_led  = r_fpga_led;
  assign debug_pin = r_debug;

endmodule

// File: tb/tb_led_share_ctrl.sv
// Directed bench for led_share_ctrl with short tick/slot/blink periods.
module tb_led_share_ctrl;

  logic       CLK25 = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req   = '0;
  logic [8:0] color = '0;
  logic [2:0] blink = '0;
  logic [2:0] grant;
  logic       d6_led, gren_led, blue_led, fpga_led, debug_pin;
  logic [2:0] pins;

  int checks = 0;
  int errors = 0;
  int k      = 0;
  int dbg_cnt;

  assign pins = {d6_led, gren_led, blue_led};

  always #5 CLK25 = ~CLK25;

  led_share_ctrl #(
    .N_REQ       (3),
    .TICK_DIV    (4),
    .SLOT_TICKS  (3),
    .BLINK_TICKS (2),
    .HB_TICKS    (5)
  ) dut (
    .CLK25     (CLK25),
    .rst_n     (rst_n),
    .req       (req),
    .color     (color),
    .blink     (blink),
    .grant     (grant),
    .d6_led    (d6_led),
    .gren_led  (gren_led),
    .blue_led  (blue_led),
    .fpga_led  (fpga_led),
    .debug_pin (debug_pin)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // Advance past the next rising edge; k counts edges since reset release.
  task automatic step();
    @(negedge CLK25);
    k++;
  endtask

  task automatic do_reset();
    @(negedge CLK25);
    rst_n = 1'b0;
    repeat (2) @(negedge CLK25);
    rst_n = 1'b1;
    k = 0;
  endtask

  // Round-robin schedule: 3-tick slots (12 edges) with a 4-edge gap.
  function automatic logic [2:0] rr_grant(input int e);
    if (e < 1)       return 3'b000;
    else if (e < 12) return 3'b001;
    else if (e < 16) return 3'b000;
    else if (e < 28) return 3'b010;
    else if (e < 32) return 3'b000;
    else if (e < 44) return 3'b100;
    else if (e < 48) return 3'b000;
    else             return 3'b001;
  endfunction

  function automatic logic [2:0] pins_for(input logic [2:0] g);
    case (g)
      3'b001:  return 3'b011;
      3'b010:  return 3'b101;
      3'b100:  return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  initial begin
    // Round-robin from reset with all three requesting.
    color = 9'b001_010_100;
    blink = 3'b000;
    req   = 3'b111;
    do_reset();
    check("rr_reset_grant", 32'(grant), 32'(3'b000));
    check("rr_reset_pins", 32'(pins), 32'(3'b111));
    check("rr_reset_fpga", 32'(fpga_led), 32'(1'b1));
    check("rr_reset_dbg", 32'(debug_pin), 32'(1'b0));
    for (int i = 1; i <= 50; i++) begin
      step();
      check("rr_grant", 32'(grant), 32'(rr_grant(k)));
      check("rr_pins", 32'(pins), 32'(pins_for(rr_grant(k))));
      check("rr_dbg", 32'(debug_pin), 32'(rr_grant(k-1) != rr_grant(k-2)));
      check("rr_fpga", 32'(fpga_led), 32'((k < 20 || k >= 40) ? 1'b1 : 1'b0));
    end

    // Blinking single owner: on until tick 2, then toggles every 2 ticks.
    req   = 3'b010;
    color = 9'b000_010_000;
    blink = 3'b010;
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      step();
      check("blink_grant", 32'(grant), 32'(3'b010));
      check("blink_pins", 32'(pins),
            32'({1'b1, (k < 8) ? 1'b0 : ((((k - 8) / 8) % 2) == 0), 1'b1}));
    end

    // Owner drops on a tick edge: gap, then the other requester after one tick.
    req   = 3'b011;
    color = 9'b000_010_100;
    blink = 3'b000;
    do_reset();
    repeat (3) step();
    check("early_owner0", 32'(grant), 32'(3'b001));
    req = 3'b010;
    step();
    check("early_gap_grant", 32'(grant), 32'(3'b000));
    check("early_gap_pins", 32'(pins), 32'(3'b111));
    repeat (3) step();
    check("early_gap_hold", 32'(grant), 32'(3'b000));
    step();
    check("early_owner1", 32'(grant), 32'(3'b010));
    check("early_pins1", 32'(pins), 32'(3'b101));

    // Colour is latched at grant; a change shows only on the next grant.
    req   = 3'b001;
    color = 9'b000_000_100;
    do_reset();
    repeat (4) step();
    check("latch_pins_a", 32'(pins), 32'(3'b011));
    color = 9'b000_000_001;
    for (int i = 5; i <= 10; i++) begin
      step();
      check("latch_hold", 32'(pins), 32'(3'b011));
    end
    req = 3'b000;
    step();
    check("latch_gap", 32'(grant), 32'(3'b000));
    req = 3'b001;
    step();
    check("latch_regrant", 32'(grant), 32'(3'b001));
    check("latch_newpins", 32'(pins), 32'(3'b110));

    // Single requester raised in IDLE, held past slot expiry, then async reset.
    req   = 3'b000;
    color = 9'b000_000_100;
    do_reset();
    step();
    check("single_idle1", 32'(grant), 32'(3'b000));
    step();
    check("single_idle2", 32'(grant), 32'(3'b000));
    req = 3'b001;
    dbg_cnt = 0;
    for (int i = 3; i <= 24; i++) begin
      step();
      check("single_grant", 32'(grant), 32'(3'b001));
      check("single_pins", 32'(pins), 32'(3'b011));
      if (debug_pin) dbg_cnt++;
      if (k == 4) check("single_dbg_pos", 32'(debug_pin), 32'(1'b1));
    end
    check("single_dbg_count", 32'(dbg_cnt), 32'(1));
    check("single_fpga_pre", 32'(fpga_led), 32'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'(3'b000));
    check("arst_pins", 32'(pins), 32'(3'b111));
    check("arst_fpga", 32'(fpga_led), 32'(1'b1));
    check("arst_dbg", 32'(debug_pin), 32'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
